// File: rtl/ms_pkg.sv
`default_nettype none
// ============================================================================
// ms_pkg: shared width default and saturation bounds for mid/side inverse
// Rev 1.0
// ============================================================================
package ms_pkg;

    localparam int c_DATA_W_DEFAULT = 16;

    // Bounds are returned wide; callers cast to their own DATA_W+1 width.
    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage : ms_pkg
`default_nettype wire

// File: rtl/ms_sat_addsub.sv
`default_nettype none
// ============================================================================
// ms_sat_addsub: combinational a+b or a-b with symmetric signed saturation
// Rev 1.0
// ============================================================================
module ms_sat_addsub
    import ms_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     sub,
    output logic signed [DATA_W-1:0] y,
    output logic                     ovf
);

    localparam logic signed [DATA_W:0] c_SAT_MAX = (DATA_W+1)'(sat_max(DATA_W));
    localparam logic signed [DATA_W:0] c_SAT_MIN = (DATA_W+1)'(sat_min(DATA_W));

    logic signed [DATA_W:0] w_a_ext;
    logic signed [DATA_W:0] w_b_ext;
    logic signed [DATA_W:0] w_res;

    // One guard bit makes the exact sum/difference unable to wrap.
    assign w_a_ext = {a[DATA_W-1], a};
    assign w_b_ext = {b[DATA_W-1], b};
    assign w_res   = sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    always_comb begin
        y   = w_res[DATA_W-1:0];
        ovf = 1'b0;
        if (w_res > c_SAT_MAX) begin
            y   = c_SAT_MAX[DATA_W-1:0];
            ovf = 1'b1;
        end else if (w_res < c_SAT_MIN) begin
            y   = c_SAT_MIN[DATA_W-1:0];
            ovf = 1'b1;
        end
    end

endmodule : ms_sat_addsub
`default_nettype wire

// File: rtl/mid_side_inverse.sv
`default_nettype none
// ============================================================================
// mid_side_inverse: registered M/S -> L/R reconstruction with bypass mode
// Rev 1.0
// ============================================================================
module mid_side_inverse
    import ms_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] mid,
    input  logic signed [DATA_W-1:0] side,
    output logic signed [DATA_W-1:0] L,
    output logic signed [DATA_W-1:0] R,
    output logic                     sat_l,
    output logic                     sat_r
);

    logic signed [DATA_W-1:0] w_sum;
    logic signed [DATA_W-1:0] w_diff;
    logic                     w_sum_ovf;
    logic                     w_diff_ovf;

    logic signed [DATA_W-1:0] r_l;
    logic signed [DATA_W-1:0] r_r;
    logic                     r_sat_l;
    logic                     r_sat_r;

    ms_sat_addsub #(.DATA_W(DATA_W)) u_add_l (
        .a   (mid),
        .b   (side),
        .sub (1'b0),
        .y   (w_sum),
        .ovf (w_sum_ovf)
    );

    ms_sat_addsub #(.DATA_W(DATA_W)) u_sub_r (
        .a   (mid),
        .b   (side),
        .sub (1'b1),
        .y   (w_diff),
        .ovf (w_diff_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_l     <= '0;
            r_r     <= '0;
            r_sat_l <= 1'b0;
            r_sat_r <= 1'b0;
        end else if (ce) begin
            if (enable) begin
                r_l     <= w_sum;
                r_r     <= w_diff;
                r_sat_l <= w_sum_ovf;
                r_sat_r <= w_diff_ovf;
            end else begin
                r_l     <= mid;
                r_r     <= side;
                r_sat_l <= 1'b0;
                r_sat_r <= 1'b0;
            end
        end
    end

    assign L     = r_l;
    assign R     = r_r;
    assign sat_l = r_sat_l;
    assign sat_r = r_sat_r;

endmodule : mid_side_inverse
`default_nettype wire

// File: tb/tb_mid_side_inverse.sv
`default_nettype none
// ============================================================================
// tb_mid_side_inverse: directed vector table plus randomized model comparison
// Rev 1.0
// ============================================================================
module tb_mid_side_inverse;

    localparam int W     = 16;
    localparam int VMAX  = (1 <<< (W - 1)) - 1;
    localparam int VMIN  = -(1 <<< (W - 1));

    typedef struct {
        bit rst;
        bit ce;
        bit en;
        int mid;
        int side;
        int l;
        int r;
        bit sl;
        bit sr;
    } vec_t;

    logic                clk;
    logic                rst;
    logic                ce;
    logic                enable;
    logic signed [W-1:0] mid;
    logic signed [W-1:0] side;
    logic signed [W-1:0] L;
    logic signed [W-1:0] R;
    logic                sat_l;
    logic                sat_r;

    int n_checks;
    int n_fail;

    mid_side_inverse #(.DATA_W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .enable (enable),
        .mid    (mid),
        .side   (side),
        .L      (L),
        .R      (R),
        .sat_l  (sat_l),
        .sat_r  (sat_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clip(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input int el, input int er,
                                 input bit esl, input bit esr);
        int al;
        int ar;
        al = L;
        ar = R;
        chk({tag, ".L"}, al, el);
        chk({tag, ".R"}, ar, er);
        chk({tag, ".sat_l"}, int'(sat_l), int'(esl));
        chk({tag, ".sat_r"}, int'(sat_r), int'(esr));
    endtask

    task automatic drive(input bit r, input bit c, input bit e, input int m, input int s);
        rst    = r;
        ce     = c;
        enable = e;
        mid    = W'(m);
        side   = W'(s);
    endtask

    vec_t tbl[$];

    initial begin
        int ml;
        int ref_l;
        int ref_r;
        bit ref_sl;
        bit ref_sr;
        int m;
        int s;
        bit r;
        bit c;
        bit e;

        n_checks = 0;
        n_fail   = 0;
        drive(1'b1, 1'b1, 1'b1, 0, 0);

        //               rst ce en   mid     side     L       R      sl sr
        tbl.push_back('{1, 1, 1, 12345,   -777,      0,      0,     0, 0});
        tbl.push_back('{1, 1, 0, -4321,  30000,      0,      0,     0, 0});
        tbl.push_back('{0, 1, 0,  1234,   5678,   1234,   5678,     0, 0});
        tbl.push_back('{0, 1, 1,  1000,    500,   1500,    500,     0, 0});
        tbl.push_back('{0, 1, 1,  -100,    -50,   -150,    -50,     0, 0});
        tbl.push_back('{0, 1, 1, 20000,  15000,  32767,   5000,     1, 0});
        tbl.push_back('{0, 1, 1,-20000, -20000, -32768,      0,     1, 0});
        tbl.push_back('{0, 1, 1, 20000, -20000,      0,  32767,     0, 1});
        tbl.push_back('{0, 1, 1,     0, -32768, -32768,  32767,     0, 1});
        tbl.push_back('{0, 1, 1,-32768, -32768, -32768,      0,     1, 0});
        tbl.push_back('{0, 1, 1, 32767,  32767,  32767,      0,     1, 0});
        tbl.push_back('{0, 0, 1,     5,      5,  32767,      0,     1, 0});
        tbl.push_back('{0, 0, 0,   -99,    123,  32767,      0,     1, 0});
        tbl.push_back('{0, 0, 1,  7777,  -7777,  32767,      0,     1, 0});
        tbl.push_back('{0, 1, 1,     7,      3,     10,      4,     0, 0});
        tbl.push_back('{0, 1, 0,-32768,  32767, -32768,  32767,     0, 0});
        tbl.push_back('{0, 1, 1,-32768,  32767,     -1, -32768,     0, 1});
        tbl.push_back('{1, 0, 1,   555,    666,      0,      0,     0, 0});
        tbl.push_back('{0, 0, 1,   555,    666,      0,      0,     0, 0});
        tbl.push_back('{0, 1, 1,   555,    666,   1221,   -111,     0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ce, tbl[i].en, tbl[i].mid, tbl[i].side);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), tbl[i].l, tbl[i].r, tbl[i].sl, tbl[i].sr);
        end

        // Random sweep: model state continues from the last table row.
        ref_l  = 1221;
        ref_r  = -111;
        ref_sl = 1'b0;
        ref_sr = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            r = ($urandom_range(63) == 0);
            c = ($urandom_range(3) != 0);
            e = ($urandom_range(1) == 1);
            case ($urandom_range(7))
                0:       m = VMIN;
                1:       m = VMAX;
                default: m = VMIN + int'($urandom_range(65535));
            endcase
            case ($urandom_range(7))
                0:       s = VMIN;
                1:       s = VMAX;
                default: s = VMIN + int'($urandom_range(65535));
            endcase
            drive(r, c, e, m, s);
            if (r) begin
                ref_l = 0; ref_r = 0; ref_sl = 0; ref_sr = 0;
            end else if (c) begin
                if (e) begin
                    ml     = m + s;
                    ref_l  = clip(ml);
                    ref_sl = (ml != ref_l);
                    ml     = m - s;
                    ref_r  = clip(ml);
                    ref_sr = (ml != ref_r);
                end else begin
                    ref_l = m; ref_r = s; ref_sl = 0; ref_sr = 0;
                end
            end
            @(posedge clk);
            #1;
            check_outputs($sformatf("rnd%0d", i), ref_l, ref_r, ref_sl, ref_sr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mid_side_inverse
`default_nettype wire

// File: doc/mid_side_inverse.md
Name: mid_side_inverse

Overview:
Converts a mid/side stereo pair back to left/right: L = mid + side, R = mid − side, with symmetric saturation to the signed output range. It sits on the playback path after mid/side processing, as a single registered stage with clock enable. A bypass mode passes mid and side straight through as L and R.

Parameters:
DATA_W, 16, signed two's-complement width of mid, side, L and R (minimum 2)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
ce  in  1  clock enable; registers update only when high
enable  in  1  1 = mid/side reconstruction, 0 = bypass
mid  in  DATA_W  signed mid sample
side  in  DATA_W  signed side sample
L  out  DATA_W  signed left output (registered)
R  out  DATA_W  signed right output (registered)
sat_l  out  1  registered flag: L was clipped on this sample
sat_r  out  1  registered flag: R was clipped on this sample

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset:
  - rst high at a rising edge sets L=0, R=0, sat_l=0, sat_r=0.
  - rst takes priority over ce.
  - rst deasserted mid-stream: the first valid output appears one edge after the first non-reset edge with ce high.
- Latency is exactly 1 cycle. mid, side and enable are sampled together at a rising edge where ce=1 and rst=0. Results are visible on L/R/sat_* immediately after that edge.
- ce low: all outputs hold their previous values; inputs are ignored.
- Bypass (enable=0): L=mid, R=side, sat_l=0, sat_r=0. No arithmetic and no clipping.
- Reconstruct (enable=1):
  - Sign-extend both inputs to DATA_W+1 bits, then form sum = mid+side and diff = mid−side. These cannot overflow.
  - Saturate each result to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−32768, 32767] at the default width.
  - Above max: output = max, flag = 1. Below min: output = min, flag = 1. Otherwise output = truncated exact value, flag = 0.
  - No halving or scaling is applied. The block is the exact inverse of a forward transform M=(L+R)/2, S=(L−R)/2, up to rounding.
- Boundary cases:
  - side = −2^(DATA_W−1) with mid = 0 gives R = max with sat_r = 1.
  - mid = side = −2^(DATA_W−1) gives L = min with sat_l = 1, and R = 0.
- Mode switch: enable may change on any cycle. Each output reflects the enable value sampled with the same data, with no blending.
- Fully combinational between input sampling and the output register. No other state.

Decomposition:
- Package ms_pkg:
  - default DATA_W constant
  - functions or localparams for SAT_MAX/SAT_MIN as a function of width
- One sub-module, ms_sat_addsub (combinational):
  - inputs a, b, and a subtract select
  - outputs the saturated DATA_W result and an overflow flag
- Instantiate ms_sat_addsub twice, once for L and once for R.
- The top level holds the bypass mux and the output registers.

Test Plan:
1. rst=1 for 2 edges with ce=1, random inputs -> L=0, R=0, sat_l=0, sat_r=0. Then enable=0, mid=1234, side=5678 -> next edge L=1234, R=5678, flags 0.
2. enable=1: (1000,500) -> L=1500, R=500. (−100,−50) -> L=−150, R=−50. Back-to-back vectors are each correct with 1-cycle latency.
3. Saturation:
   - (20000,15000) -> L=32767, sat_l=1; R=5000, sat_r=0.
   - (−20000,−20000) -> L=−32768, sat_l=1; R=0.
   - (20000,−20000) -> L=0; R=32767, sat_r=1.
4. Extremes:
   - (0,−32768) -> L=−32768, R=32767, sat_r=1, sat_l=0.
   - (−32768,−32768) -> L=−32768, sat_l=1; R=0.
   - (32767,32767) -> L=32767, sat_l=1; R=0.
5. ce=0 for 3 cycles while inputs change -> outputs hold the last values. Raising ce resumes with 1-cycle latency. rst asserted while ce=0 still clears all outputs.
6. Random sweep of 10k vectors with random enable and ce -> outputs match a reference model (clip(mid±side), or passthrough) on every edge.
